weights_sram_writer: RTL and testbench
======================================

Name: weights_sram_writer

Overview:
- Write-side counterpart of the systolic-array weights fetch path.
- Accepts a signed int8 weight stream over a valid/ready handshake and packs 3 weights per SRAM word in lanes [7:0], [15:8] and [23:16]; [31:24] is zero.
- Writes one channel's kernel block to sequential addresses starting at (channel-1)*W_kernels, then pulses done.
- This is the same layout the weights fetch unit reads back into the array.

Parameters:
- ADR_W, 16, SRAM address width.
- SRAM_W, 32, SRAM data width; must be ≥24.

Ports:
- i_clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- data  in  convolution (cvxif_pkg)  layer descriptor; only W_kernels is used, as words per channel
- i_start  in  1  request to write one channel; sampled only in IDLE
- i_channel  in  7  target channel, 1-based; 0 is illegal
- i_w_valid  in  1  weight byte valid
- i_w_data  in  8 signed  weight byte
- o_w_ready  out  1  writer accepts byte this cycle
- o_sram_addr  out  ADR_W  write address
- o_sram_wren  out  1  write enable, one cycle per word
- o_sram_wdata  out  SRAM_W  packed word
- o_busy  out  1  high in any state except IDLE
- o_done  out  1  one-cycle pulse when the channel block is complete
- o_err  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - state=IDLE; word_cnt=0; lane=0; pack register=0.
  - All outputs are 0, including o_sram_addr and o_sram_wdata.
  - Reset mid-operation abandons the block. No partial word is written and no done is issued.
- Start latch in IDLE: the cycle i_start=1 is seen, the block latches W_kernels and base=((i_channel-1)*W_kernels) truncated to ADR_W.
- States:
  - IDLE: o_w_ready=0.
    - i_start && i_channel!=0 && W_kernels!=0 -> FILL, with word_cnt=0, lane=0, pack=0.
    - i_start with i_channel==0 or W_kernels==0 -> o_err=1 next cycle, remain IDLE.
  - FILL: o_w_ready=1.
    - Each handshake (i_w_valid && o_w_ready) writes i_w_data into pack lane `lane`, then lane++.
    - The handshake on lane 2 -> WRITE.
    - No handshake -> hold state and contents.
  - WRITE: exactly one cycle.
    - o_w_ready=0; o_sram_wren=1.
    - o_sram_addr=base+word_cnt, mod 2^ADR_W.
    - o_sram_wdata={zeros, lane2, lane1, lane0}.
    - Next state: DONE if word_cnt==W_kernels-1. Otherwise FILL, with word_cnt++, lane=0, pack=0.
  - DONE: o_done=1 for one cycle -> IDLE.
- Outputs are decoded from registered state and registered data, so there are no combinational paths from inputs to outputs except none.
- o_sram_wren=0, and addr/wdata are held, outside WRITE.
- Throughput: minimum 4 cycles per word (3 accepts + 1 write).
- Latency: last byte accepted at cycle t -> write at t+1. For the final word, o_done is at t+2.
- i_start outside IDLE is ignored. No queuing.
- i_channel and data changes after the start latch have no effect until the next start.
- Bytes offered while o_w_ready=0 are not consumed; the source must hold them.
- Sign is not altered: bytes are stored raw (0x80 stays 0x80).
- A block ends only on a word boundary. The stream carries exactly 3*W_kernels bytes per channel.

Decomposition:
- cvxif_pkg additions:
  - localparam WEIGHTS_PER_WORD=3.
  - typedef enum logic [1:0] {WW_IDLE, WW_FILL, WW_WRITE, WW_DONE} weights_wr_state_t.
- Natural sub-module: weights_byte_packer.
  - Holds the lane counter and 3-byte pack register.
  - Ports: clear, accept, byte_in, full, word_out.
- The top holds the FSM, address/word counters, error/done pulses and the SRAM port.

Test Plan:
1. ch=1, W_kernels=2, bytes 0x01..0x06, valid always high -> writes addr0=0x00030201 and addr1=0x00060504, 4 cycles apart; o_done 1 cycle after the second write; o_busy low afterwards.
2. ch=3, W_kernels=4, 12 bytes -> wren on addresses 8, 9, 10, 11 only; exactly 4 write pulses; one o_done.
3. Case 1 with i_w_valid toggling every other cycle, plus valid held high during WRITE -> identical SRAM contents; o_w_ready=0 in every WRITE cycle; no byte dropped or duplicated.
4. Start with ch=0, then with W_kernels=0 -> o_err pulses once each; no o_sram_wren; o_busy stays 0; o_w_ready stays 0.
5. ch=1, W_kernels=1, two bytes accepted, then i_rst=1 for one cycle -> all outputs 0, no write. A restart with bytes 0xFF, 0x80, 0x7F then writes addr0=0x007F80FF, with no stale lanes.
6. i_start pulsed with ch=5 while busy on ch=2 (W_kernels=2) -> only addresses 2 and 3 are written; the second start is ignored; a single o_done.

Source files
------------

// File: rtl/cvxif_pkg.sv
// Shared types for the convolution accelerator: the layer descriptor and the
// weights SRAM writer state encoding.
package cvxif_pkg;

  localparam int KW_W = 16;
  localparam int WEIGHTS_PER_WORD = 3;

  typedef struct packed {
    logic [KW_W-1:0] W_kernels;
    logic [15:0]     H_in;
    logic [15:0]     W_in;
    logic [7:0]      C_in;
    logic [7:0]      C_out;
    logic [3:0]      K;
    logic [3:0]      stride;
  } convolution;

  typedef enum logic [1:0] {WW_IDLE, WW_FILL, WW_WRITE, WW_DONE} weights_wr_state_t;

endpackage

// File: rtl/weights_sram_writer_packer.sv
// Collects signed weight bytes into a 3-lane word, lane 0 in the low byte.
// full flags the accept that lands in the last lane, so the writer can leave
// FILL on that same edge without a bubble cycle.
module weights_byte_packer
  import cvxif_pkg::*;
(
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          clear,
  input  logic                          accept,
  input  logic [7:0]                    byte_in,
  output logic                          full,
  output logic [WEIGHTS_PER_WORD*8-1:0] word_out
);

  logic [1:0]                        lane;
  logic [WEIGHTS_PER_WORD-1:0][7:0]  pack;

  always_ff @(posedge i_clk) begin
    if (i_rst || clear) begin
      lane <= '0;
      pack <= '0;
    end else if (accept) begin
      pack[lane] <= byte_in;
      lane       <= lane + 2'd1;
    end
  end

  assign full     = accept && (lane == 2'(WEIGHTS_PER_WORD - 1));
  assign word_out = pack;

endmodule

// File: rtl/weights_sram_writer.sv
// Packs a weight byte stream into SRAM words and writes one channel's kernel
// block at (channel-1)*W_kernels onward, then pulses done.
//
// state    | meaning
// WW_IDLE  | waiting for a start; rejects channel 0 or empty blocks with err
// WW_FILL  | accepting bytes into the packer (ready high)
// WW_WRITE | one-cycle SRAM write of the packed word
// WW_DONE  | one-cycle done pulse, then back to idle
module weights_sram_writer
  import cvxif_pkg::*;
#(
  parameter int ADR_W  = 16,
  parameter int SRAM_W = 32
)(
  input  logic              i_clk,
  input  logic              i_rst,
  input  convolution        data,
  input  logic              i_start,
  input  logic [6:0]        i_channel,
  input  logic              i_w_valid,
  input  logic signed [7:0] i_w_data,
  output logic              o_w_ready,
  output logic [ADR_W-1:0]  o_sram_addr,
  output logic              o_sram_wren,
  output logic [SRAM_W-1:0] o_sram_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  weights_wr_state_t state;

  logic [KW_W-1:0]   word_cnt;
  logic [KW_W-1:0]   wk_q;
  logic [ADR_W-1:0]  base_q;
  logic [ADR_W-1:0]  addr_q;
  logic [SRAM_W-1:0] wdata_q;
  logic              ready_q;
  logic              wren_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              start_ok;
  logic [6:0]        ch_m1;
  logic [ADR_W-1:0]  base_next;
  logic              pk_clear;
  logic              pk_accept;
  logic              pk_full;
  logic [WEIGHTS_PER_WORD*8-1:0] pk_word;

  logic unused_data;
  assign unused_data = ^{data.H_in, data.W_in, data.C_in, data.C_out, data.K, data.stride};

  assign start_ok  = i_start && (i_channel != 7'd0) && (data.W_kernels != '0);
  assign ch_m1     = i_channel - 7'd1;
  // The low ADR_W bits of a product only depend on the low ADR_W bits of the operands.
  assign base_next = ADR_W'(ch_m1) * ADR_W'(data.W_kernels);

  assign pk_accept = i_w_valid && ready_q;
  assign pk_clear  = ((state == WW_IDLE) && start_ok) || (state == WW_WRITE);

  weights_byte_packer u_packer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .clear    (pk_clear),
    .accept   (pk_accept),
    .byte_in  (i_w_data),
    .full     (pk_full),
    .word_out (pk_word)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= WW_IDLE;
      word_cnt <= '0;
      wk_q     <= '0;
      base_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ready_q  <= 1'b0;
      wren_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wren_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        WW_IDLE: begin
          if (i_start) begin
            wk_q   <= data.W_kernels;
            base_q <= base_next;
            if (start_ok) begin
              state    <= WW_FILL;
              word_cnt <= '0;
              ready_q  <= 1'b1;
              busy_q   <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        WW_FILL: begin
          if (pk_full) begin
            state   <= WW_WRITE;
            ready_q <= 1'b0;
            wren_q  <= 1'b1;
            addr_q  <= base_q + ADR_W'(word_cnt);
          end
        end
        WW_WRITE: begin
          wdata_q <= SRAM_W'(pk_word);
          if (word_cnt == wk_q - KW_W'(1)) begin
            state  <= WW_DONE;
            done_q <= 1'b1;
          end else begin
            state    <= WW_FILL;
            word_cnt <= word_cnt + KW_W'(1);
            ready_q  <= 1'b1;
          end
        end
        WW_DONE: begin
          state  <= WW_IDLE;
          busy_q <= 1'b0;
        end
        default: state <= WW_IDLE;
      endcase
    end
  end

  // During WRITE the packer still holds the complete word; afterwards wdata_q keeps it.
  assign o_sram_wdata = (state == WW_WRITE) ? SRAM_W'(pk_word) : wdata_q;
  assign o_sram_addr  = addr_q;
  assign o_sram_wren  = wren_q;
  assign o_w_ready    = ready_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_weights_sram_writer.sv
// Scenario bench for weights_sram_writer with a queue-based layout model.
module tb_weights_sram_writer;
  import cvxif_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  convolution  conv;
  logic        start;
  logic [6:0]  chan;
  logic        w_valid;
  logic [7:0]  w_data;
  logic        w_ready;
  logic [15:0] sram_addr;
  logic        sram_wren;
  logic [31:0] sram_wdata;
  logic        busy;
  logic        done;
  logic        err;

  weights_sram_writer #(.ADR_W(16), .SRAM_W(32)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .data         (conv),
    .i_start      (start),
    .i_channel    (chan),
    .i_w_valid    (w_valid),
    .i_w_data     (w_data),
    .o_w_ready    (w_ready),
    .o_sram_addr  (sram_addr),
    .o_sram_wren  (sram_wren),
    .o_sram_wdata (sram_wdata),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_pass = 0;

  logic [15:0] got_addr[$];
  logic [31:0] got_data[$];
  int          got_cyc[$];
  int done_cnt, err_cnt, done_cyc, ready_in_write, busy_seen, ready_seen;

  always @(negedge clk) begin
    if (sram_wren) begin
      got_addr.push_back(sram_addr);
      got_data.push_back(sram_wdata);
      got_cyc.push_back(cyc);
      if (w_ready) ready_in_write++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err) err_cnt++;
    if (busy) busy_seen++;
    if (w_ready) ready_seen++;
  end

  logic [7:0]  src[$];
  logic [15:0] exp_addr[$];
  logic [31:0] exp_data[$];

  // Layout model: word w of channel ch lives at (ch-1)*wk + w, bytes little-endian in lanes.
  function automatic void build_expected(input int chn, input int wk);
    exp_addr.delete();
    exp_data.delete();
    for (int w = 0; w < wk; w++) begin
      exp_addr.push_back(16'(((chn - 1) * wk + w) % 65536));
      exp_data.push_back({8'h00, src[3*w+2], src[3*w+1], src[3*w]});
    end
  endfunction

  function automatic void clear_mon();
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
    done_cnt = 0; err_cnt = 0; done_cyc = 0;
    ready_in_write = 0; busy_seen = 0; ready_seen = 0;
  endfunction

  function automatic void fill_random(input int n);
    src.delete();
    for (int i = 0; i < n; i++) src.push_back(8'($urandom_range(0, 255)));
  endfunction

  task automatic do_start(input int chn, input int wk);
    conv.W_kernels = 16'(wk);
    chan  = 7'(chn);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: valid always; 1: toggling, held high while not ready; 2: random
  task automatic feed(input int mode, input int budget, input int first, output int consumed, output bit timeout);
    int idx;
    int d0;
    int n;
    bit take;
    idx = first; d0 = done_cnt; n = 0; timeout = 1'b0;
    while (done_cnt == d0) begin
      if (n >= budget) begin
        timeout = 1'b1;
        break;
      end
      if (idx < src.size()) begin
        case (mode)
          0:       w_valid = 1'b1;
          1:       w_valid = (n % 2 == 0) || !w_ready;
          default: w_valid = 1'($urandom_range(0, 1));
        endcase
        w_data = src[idx];
      end else begin
        w_valid = 1'b0;
        w_data  = 8'h00;
      end
      @(negedge clk);
      take = w_valid && w_ready;
      @(posedge clk); #1;
      if (take) idx++;
      n++;
    end
    w_valid  = 1'b0;
    consumed = idx;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (sram_wren !== 1'b0) $display("FAIL reset_wren got %b want 0", sram_wren); else n_pass++;
    n_checks++; if (sram_addr !== 16'h0) $display("FAIL reset_addr got %h want 0000", sram_addr); else n_pass++;
    n_checks++; if (sram_wdata !== 32'h0) $display("FAIL reset_wdata got %h want 0", sram_wdata); else n_pass++;
    n_checks++; if (w_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", w_ready); else n_pass++;
    n_checks++; if ({busy, done, err} !== 3'b000) $display("FAIL reset_flags busy/done/err got %b want 000", {busy, done, err}); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int cons;
    bit to;
    clear_mon();
    src = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    do_start(1, 2);
    feed(0, 60, 0, cons, to);
    @(negedge clk);
    n_checks++; if (to) $display("FAIL basic_timeout got no done want done"); else n_pass++;
    n_checks++; if (got_addr.size() !== 2) $display("FAIL basic_nwrites got %0d want 2", got_addr.size()); else n_pass++;
    if (got_addr.size() == 2) begin
      n_checks++; if (got_addr[0] !== 16'd0 || got_data[0] !== 32'h00030201) $display("FAIL basic_word0 got %h/%h want 0000/00030201", got_addr[0], got_data[0]); else n_pass++;
      n_checks++; if (got_addr[1] !== 16'd1 || got_data[1] !== 32'h00060504) $display("FAIL basic_word1 got %h/%h want 0001/00060504", got_addr[1], got_data[1]); else n_pass++;
      n_checks++; if (got_cyc[1] - got_cyc[0] !== 4) $display("FAIL basic_gap got %0d want 4", got_cyc[1] - got_cyc[0]); else n_pass++;
      n_checks++; if (done_cyc - got_cyc[1] !== 1) $display("FAIL basic_done_lat got %0d want 1", done_cyc - got_cyc[1]); else n_pass++;
    end
    n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_after got %b want 0", busy); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL basic_done_cnt got %0d want 1", done_cnt); else n_pass++;
  endtask

  task automatic test_addresses();
    int cons;
    bit to;
    clear_mon();
    fill_random(12);
    build_expected(3, 4);
    do_start(3, 4);
    feed(0, 80, 0, cons, to);
    @(negedge clk);
    n_checks++; if (to) $display("FAIL addr_timeout got no done want done"); else n_pass++;
    n_checks++; if (got_addr.size() !== 4) $display("FAIL addr_nwrites got %0d want 4", got_addr.size()); else n_pass++;
    for (int i = 0; i < got_addr.size() && i < 4; i++) begin
      n_checks++;
      if (got_addr[i] !== 16'(8 + i) || got_data[i] !== exp_data[i])
        $display("FAIL addr_word%0d got %h/%h want %h/%h", i, got_addr[i], got_data[i], 16'(8 + i), exp_data[i]);
      else n_pass++;
    end
    n_checks++; if (done_cnt !== 1) $display("FAIL addr_done_cnt got %0d want 1", done_cnt); else n_pass++;
  endtask

  task automatic test_stall();
    int cons;
    bit to;
    clear_mon();
    src = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    build_expected(1, 2);
    do_start(1, 2);
    feed(1, 80, 0, cons, to);
    @(negedge clk);
    n_checks++; if (to) $display("FAIL stall_timeout got no done want done"); else n_pass++;
    n_checks++; if (got_addr.size() !== exp_addr.size()) $display("FAIL stall_nwrites got %0d want %0d", got_addr.size(), exp_addr.size()); else n_pass++;
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      n_checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i])
        $display("FAIL stall_word%0d got %h/%h want %h/%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      else n_pass++;
    end
    n_checks++; if (ready_in_write !== 0) $display("FAIL stall_ready_in_write got %0d want 0", ready_in_write); else n_pass++;
    n_checks++; if (cons !== 6) $display("FAIL stall_consumed got %0d want 6", cons); else n_pass++;
  endtask

  task automatic test_random_blocks();
    int cons;
    bit to;
    int chn, wk, mode;
    for (int it = 0; it < 5; it++) begin
      clear_mon();
      if (it == 4) begin
        chn = 100; wk = 700; mode = 0;
      end else begin
        chn = $urandom_range(1, 127); wk = $urandom_range(1, 5); mode = 2;
      end
      fill_random(3 * wk);
      build_expected(chn, wk);
      do_start(chn, wk);
      feed(mode, 12 * wk + 40, 0, cons, to);
      @(negedge clk);
      n_checks++; if (to) $display("FAIL rand%0d_timeout got no done want done", it); else n_pass++;
      n_checks++; if (got_addr.size() !== exp_addr.size()) $display("FAIL rand%0d_nwrites got %0d want %0d", it, got_addr.size(), exp_addr.size()); else n_pass++;
      for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
        n_checks++;
        if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i])
          $display("FAIL rand%0d_word%0d got %h/%h want %h/%h", it, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
        else n_pass++;
      end
      n_checks++; if (cons !== 3 * wk) $display("FAIL rand%0d_consumed got %0d want %0d", it, cons, 3 * wk); else n_pass++;
      n_checks++; if (ready_in_write !== 0) $display("FAIL rand%0d_ready_in_write got %0d want 0", it, ready_in_write); else n_pass++;
    end
  endtask

  task automatic test_errors();
    clear_mon();
    do_start(0, 3);
    repeat (2) @(posedge clk);
    #1;
    do_start(4, 0);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (err_cnt !== 2) $display("FAIL err_pulses got %0d want 2", err_cnt); else n_pass++;
    n_checks++; if (got_addr.size() !== 0) $display("FAIL err_writes got %0d want 0", got_addr.size()); else n_pass++;
    n_checks++; if (busy_seen !== 0) $display("FAIL err_busy got %0d cycles want 0", busy_seen); else n_pass++;
    n_checks++; if (ready_seen !== 0) $display("FAIL err_ready got %0d cycles want 0", ready_seen); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cons;
    bit to;
    clear_mon();
    do_start(1, 1);
    w_valid = 1'b1;
    w_data  = 8'hAA;
    @(posedge clk); #1;
    w_data  = 8'hBB;
    @(posedge clk); #1;
    w_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if ({sram_wren, w_ready, busy, done, err} !== 5'b0) $display("FAIL rmid_flags got %b want 00000", {sram_wren, w_ready, busy, done, err}); else n_pass++;
    n_checks++; if (sram_addr !== 16'h0 || sram_wdata !== 32'h0) $display("FAIL rmid_bus got %h/%h want 0000/00000000", sram_addr, sram_wdata); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (got_addr.size() !== 0 || done_cnt !== 0) $display("FAIL rmid_no_write got %0d writes %0d dones want 0 0", got_addr.size(), done_cnt); else n_pass++;
    src = '{8'hFF, 8'h80, 8'h7F};
    do_start(1, 1);
    feed(0, 40, 0, cons, to);
    @(negedge clk);
    n_checks++; if (to) $display("FAIL rmid_timeout got no done want done"); else n_pass++;
    n_checks++; if (got_addr.size() !== 1) $display("FAIL rmid_nwrites got %0d want 1", got_addr.size()); else n_pass++;
    if (got_addr.size() >= 1) begin
      n_checks++; if (got_addr[0] !== 16'h0 || got_data[0] !== 32'h007F80FF) $display("FAIL rmid_word got %h/%h want 0000/007f80ff", got_addr[0], got_data[0]); else n_pass++;
    end
  endtask

  task automatic test_ignore_start();
    int cons;
    bit to;
    clear_mon();
    fill_random(6);
    build_expected(2, 2);
    do_start(2, 2);
    w_valid = 1'b1;
    w_data  = src[0];
    start   = 1'b1;
    chan    = 7'd5;
    conv.W_kernels = 16'd9;
    @(posedge clk); #1;
    start = 1'b0;
    feed(0, 60, 1, cons, to);
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (to) $display("FAIL ign_timeout got no done want done"); else n_pass++;
    n_checks++; if (got_addr.size() !== 2) $display("FAIL ign_nwrites got %0d want 2", got_addr.size()); else n_pass++;
    for (int i = 0; i < got_addr.size() && i < 2; i++) begin
      n_checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i])
        $display("FAIL ign_word%0d got %h/%h want %h/%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      else n_pass++;
    end
    n_checks++; if (done_cnt !== 1) $display("FAIL ign_done_cnt got %0d want 1", done_cnt); else n_pass++;
    n_checks++; if (busy !== 1'b0 || err_cnt !== 0) $display("FAIL ign_idle got busy=%b err=%0d want 0 0", busy, err_cnt); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    conv = '0;
    start = 1'b0;
    chan = 7'd0;
    w_valid = 1'b0;
    w_data = 8'h00;
    test_reset();
    test_basic();
    test_addresses();
    test_stall();
    test_random_blocks();
    test_errors();
    test_reset_mid();
    test_ignore_start();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
